genius_seq_engine: RTL and testbench

Parametrised sequence engine for the Genius memory game. It generates the FPGA symbol sequence internally with an LFSR and stores it in an on-chip register file. It plays the sequence on LEDs at the game-rate tick, then captures and checks user button presses step by step, with a per-press timeout. It replaces the separate round, FPGA, user and time counters and the wide compare registers, and is generalised in channel count, maximum round depth and timeout.

---
 rtl/genius_seq_engine.sv | 126 ++++++++++++
 tb/tb_genius_seq_engine.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/genius_seq_engine.sv
// genius_seq_engine: Genius memory-game sequencer (LFSR symbol generation, LED playback, press checking with timeout).
// Ports: CLOCK_50/reset_n clock and async active-low reset; start_i/target_i start a game with a round goal;
// tick_i game-rate enable; btn_i button pulses; leds_o one-hot LEDs; round_o/points_o/time_o registered status;
// busy_o/user_turn_o/match_o/win_o/lose_o game flags.
module genius_seq_engine #(
  parameter int N_CH = 4,
  parameter int MAX_ROUNDS = 16,
  parameter int TIMEOUT_TICKS = 5,
  parameter logic [15:0] SEED = 16'hACE1,
  localparam int SYM_W = $clog2(N_CH),
  localparam int RND_W = $clog2(MAX_ROUNDS + 1)
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [RND_W-1:0] target_i,
  input  logic             tick_i,
  input  logic [N_CH-1:0]  btn_i,
  output logic [N_CH-1:0]  leds_o,
  output logic [RND_W-1:0] round_o,
  output logic [7:0]       points_o,
  output logic [3:0]       time_o,
  output logic             busy_o,
  output logic             user_turn_o,
  output logic             match_o,
  output logic             win_o,
  output logic             lose_o
);
  localparam int AW = MAX_ROUNDS > 1 ? $clog2(MAX_ROUNDS) : 1;
  typedef enum logic [2:0] {IDLE, APPEND, PLAY_ON, PLAY_OFF, WAIT_IN, WIN, LOSE} state_t;
  state_t state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [RND_W-1:0] round_q, round_d, idx_q, idx_d, tgt_q, tgt_d, tgt_clamp;
  logic [7:0] points_q, points_d;
  logic [3:0] timer_q, timer_d;
  logic match_q, match_d;
  logic [N_CH-1:0] echo_q, echo_d, exp_oh;
  logic [SYM_W-1:0] mem_q [MAX_ROUNDS];
  logic last;
  assign exp_oh = N_CH'(1) << mem_q[idx_q[AW-1:0]];
  assign last = idx_q == round_q - RND_W'(1);
  assign tgt_clamp = target_i == '0 ? RND_W'(1) : (target_i > RND_W'(MAX_ROUNDS) ? RND_W'(MAX_ROUNDS) : target_i);
  // Free-running so the sequence depends on when the player presses start.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    idx_d = idx_q;
    tgt_d = tgt_q;
    points_d = points_q;
    timer_d = timer_q;
    match_d = 1'b0;
    echo_d = '0;
    case (state_q)
      IDLE, WIN, LOSE: if (start_i) begin
        state_d = APPEND;
        tgt_d = tgt_clamp;
        round_d = '0;
        points_d = '0;
      end
      APPEND: begin
        round_d = round_q + RND_W'(1);
        idx_d = '0;
        state_d = PLAY_ON;
      end
      PLAY_ON: if (tick_i) state_d = PLAY_OFF;
      PLAY_OFF: if (tick_i) begin
        state_d = last ? WAIT_IN : PLAY_ON;
        idx_d = last ? '0 : idx_q + RND_W'(1);
        timer_d = last ? 4'(TIMEOUT_TICKS) : timer_q;
      end
      WAIT_IN: begin
        echo_d = btn_i;
        if (btn_i == exp_oh) begin
          match_d = 1'b1;
          timer_d = last ? 4'd0 : 4'(TIMEOUT_TICKS);
          idx_d = last ? idx_q : idx_q + RND_W'(1);
          points_d = last && points_q != 8'd255 ? points_q + 8'd1 : points_q;
          state_d = !last ? WAIT_IN : (round_q == tgt_q ? WIN : APPEND);
        end else if (btn_i != '0) begin
          state_d = LOSE;
          timer_d = 4'd0;
        end else if (tick_i) begin
          timer_d = timer_q - 4'd1;
          state_d = timer_q == 4'd1 ? LOSE : WAIT_IN;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lfsr_q <= SEED;
      round_q <= '0;
      idx_q <= '0;
      tgt_q <= '0;
      points_q <= '0;
      timer_q <= '0;
      match_q <= 1'b0;
      echo_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      round_q <= round_d;
      idx_q <= idx_d;
      tgt_q <= tgt_d;
      points_q <= points_d;
      timer_q <= timer_d;
      match_q <= match_d;
      echo_q <= echo_d;
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (state_q == APPEND) mem_q[round_q[AW-1:0]] <= lfsr_q[SYM_W-1:0];
  end
  assign leds_o = state_q == PLAY_ON ? exp_oh : (state_q == WAIT_IN ? echo_q : '0);
  assign round_o = round_q;
  assign points_o = points_q;
  assign time_o = timer_q;
  assign busy_o = !(state_q == IDLE || state_q == WIN || state_q == LOSE);
  assign user_turn_o = state_q == WAIT_IN;
  assign match_o = match_q;
  assign win_o = state_q == WIN;
  assign lose_o = state_q == LOSE;
endmodule

// File: tb/tb_genius_seq_engine.sv
// tb_genius_seq_engine: randomized game-level check of genius_seq_engine against a queue-based model.
module tb_genius_seq_engine;
  localparam int N_CH = 4;
  localparam int MAX_ROUNDS = 16;
  localparam int T = 5;
  localparam int RND_W = 5;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic tick_i = 1'b0;
  logic [RND_W-1:0] target_i = '0;
  logic [N_CH-1:0] btn_i = '0;
  logic [N_CH-1:0] leds_o;
  logic [RND_W-1:0] round_o;
  logic [7:0] points_o;
  logic [3:0] time_o;
  logic busy_o, user_turn_o, match_o, win_o, lose_o;
  logic [15:0] lfsr_m;
  int n_cmp = 0;
  int n_bad = 0;
  int seq[$];
  int tgt_m;
  int pts_m;
  always #10 clk = ~clk;
  genius_seq_engine #(.N_CH(N_CH), .MAX_ROUNDS(MAX_ROUNDS), .TIMEOUT_TICKS(T), .SEED(SEED)) dut (
    .CLOCK_50(clk), .reset_n(rst_n), .start_i(start_i), .target_i(target_i), .tick_i(tick_i),
    .btn_i(btn_i), .leds_o(leds_o), .round_o(round_o), .points_o(points_o), .time_o(time_o),
    .busy_o(busy_o), .user_turn_o(user_turn_o), .match_o(match_o), .win_o(win_o), .lose_o(lose_o)
  );
  // Spec-level LFSR: SEED at reset, taps 16,14,13,11, one step per clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= SEED;
    else lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(negedge clk);
  endtask
  function automatic logic [N_CH-1:0] oh(input int s);
    return N_CH'(1) << s;
  endfunction
  task automatic begin_game(input int t);
    start_i = 1'b1;
    target_i = RND_W'(t);
    cyc;
    start_i = 1'b0;
    target_i = RND_W'($urandom);
    tgt_m = t == 0 ? 1 : (t > MAX_ROUNDS ? MAX_ROUNDS : t);
    seq.delete();
    pts_m = 0;
    chk("start_busy", 32'(busy_o), 1);
    chk("start_win_clr", 32'(win_o), 0);
    chk("start_lose_clr", 32'(lose_o), 0);
    chk("start_points", 32'(points_o), 0);
  endtask
  task automatic append;
    seq.push_back(int'(lfsr_m[1:0]));
    cyc;
    chk("round", 32'(round_o), seq.size());
    chk("first_led", 32'(leds_o), 32'(oh(seq[0])));
  endtask
  task automatic play;
    foreach (seq[i]) begin
      repeat ($urandom_range(2, 0)) begin
        chk("led_on", 32'(leds_o), 32'(oh(seq[i])));
        start_i = $urandom_range(3, 0) == 0;
        cyc;
        start_i = 1'b0;
      end
      chk("led_on", 32'(leds_o), 32'(oh(seq[i])));
      tick_i = 1'b1;
      cyc;
      tick_i = 1'b0;
      repeat ($urandom_range(2, 0)) begin
        chk("led_off", 32'(leds_o), 0);
        cyc;
      end
      chk("led_off", 32'(leds_o), 0);
      tick_i = 1'b1;
      cyc;
      tick_i = 1'b0;
    end
    chk("user_turn", 32'(user_turn_o), 1);
    chk("time_load", 32'(time_o), T);
    chk("round_hold", 32'(round_o), seq.size());
  endtask
  task automatic ticks(input int k);
    for (int j = 1; j <= k; j++) begin
      if ($urandom_range(1, 0) == 1) begin
        cyc;
        chk("time_hold", 32'(time_o), T - j + 1);
      end
      tick_i = 1'b1;
      cyc;
      tick_i = 1'b0;
      chk("countdown", 32'(time_o), T - j);
    end
  endtask
  task automatic press(input int i);
    ticks($urandom_range(T - 1, 0));
    btn_i = oh(seq[i]);
    tick_i = 1'($urandom_range(1, 0));
    cyc;
    btn_i = '0;
    tick_i = 1'b0;
    chk("match", 32'(match_o), 1);
    if (i < seq.size() - 1) begin
      chk("reload", 32'(time_o), T);
      chk("echo", 32'(leds_o), 32'(oh(seq[i])));
      chk("turn_hold", 32'(user_turn_o), 1);
      cyc;
      chk("match_pulse", 32'(match_o), 0);
      chk("echo_clear", 32'(leds_o), 0);
    end else begin
      pts_m = pts_m == 255 ? 255 : pts_m + 1;
      chk("points", 32'(points_o), pts_m);
      chk("time_exit", 32'(time_o), 0);
      if (seq.size() == tgt_m) begin
        chk("win", 32'(win_o), 1);
        chk("win_busy", 32'(busy_o), 0);
        chk("win_round", 32'(round_o), seq.size());
      end else begin
        chk("next_busy", 32'(busy_o), 1);
        chk("next_turn", 32'(user_turn_o), 0);
      end
    end
  endtask
  // kind: 0 wrong one-hot, 1 multi-hot, 2 timeout; fail_rnd 0 means play to the win.
  task automatic game(input int t, input int fail_rnd, input int kind, input int fi_in);
    int fi;
    begin_game(t);
    while (1) begin
      append;
      play;
      if (seq.size() == fail_rnd) begin
        fi = fi_in < 0 ? $urandom_range(seq.size() - 1, 0) : fi_in;
        for (int i = 0; i < fi; i++) press(i);
        if (kind == 2) ticks(T);
        else begin
          btn_i = kind == 1 ? 4'b0011 : oh((seq[fi] + $urandom_range(3, 1)) % 4);
          cyc;
          btn_i = '0;
        end
        chk("lose", 32'(lose_o), 1);
        chk("lose_busy", 32'(busy_o), 0);
        chk("lose_points", 32'(points_o), pts_m);
        chk("lose_time", 32'(time_o), 0);
        chk("lose_leds", 32'(leds_o), 0);
        return;
      end
      for (int i = 0; i < seq.size(); i++) press(i);
      if (seq.size() == tgt_m) begin
        cyc;
        chk("win_hold", 32'(win_o), 1);
        chk("win_match_clr", 32'(match_o), 0);
        chk("win_leds", 32'(leds_o), 0);
        return;
      end
    end
  endtask
  initial begin
    repeat (3) cyc;
    chk("rst_leds", 32'(leds_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_round", 32'(round_o), 0);
    rst_n = 1'b1;
    repeat ($urandom_range(4, 1)) cyc;
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_time", 32'(time_o), 0);
    game(2, 0, 0, -1);
    game(5, 3, 0, 1);
    game(4, 2, 1, -1);
    game(6, 1, 2, 0);
    game(3, 3, 2, -1);
    game(0, 0, 0, -1);
    chk("target0_round", 32'(round_o), 1);
    game(31, 0, 0, -1);
    chk("clamp_round", 32'(round_o), MAX_ROUNDS);
    repeat (6) begin
      repeat ($urandom_range(3, 0)) cyc;
      game($urandom_range(8, 1), $urandom_range(8, 0), $urandom_range(2, 0), -1);
    end
    begin_game(10);
    repeat (2) begin
      append;
      play;
      for (int i = 0; i < seq.size(); i++) press(i);
    end
    append;
    chk("pre_rst_round", 32'(round_o), 3);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_leds", 32'(leds_o), 0);
    chk("arst_round", 32'(round_o), 0);
    chk("arst_points", 32'(points_o), 0);
    chk("arst_time", 32'(time_o), 0);
    chk("arst_flags", 32'({busy_o, user_turn_o, match_o, win_o, lose_o}), 0);
    cyc;
    cyc;
    rst_n = 1'b1;
    cyc;
    chk("post_rst_busy", 32'(busy_o), 0);
    chk("post_rst_round", 32'(round_o), 0);
    game(2, 0, 0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
